// File: rtl/pinball_game_fsm_pkg.sv
// Shared game-flow definitions: default tuning constants, the state encoding
// and a width helper for the frame timers.
package defines;

  localparam int DEF_LIFE_INIT      = 3;
  localparam int DEF_LIFE_MAX       = 9;
  localparam int DEF_SCORE_TARGET   = 10;
  localparam int DEF_LEVEL_MAX      = 5;
  localparam int DEF_DELAY_FRAMES   = 60;
  localparam int DEF_HOLDOFF_FRAMES = 8;

  typedef enum logic [2:0] {
    SERVE    = 3'd0,
    PLAY     = 3'd1,
    PAUSED   = 3'd2,
    LOST     = 3'd3,
    LEVEL_UP = 3'd4,
    OVER     = 3'd5,
    WIN      = 3'd6
  } game_state_t;

  // Bits needed to hold a frame count of 0..frames (at least one bit).
  function automatic int timer_width(input int frames);
    return (frames < 1) ? 1 : $clog2(frames + 1);
  endfunction

endpackage

// File: rtl/pinball_game_fsm_if.sv
// Signal bundle between the collision/key logic and the game-flow controller.
// The controller is the slave; the surrounding pinball logic is the master.
interface pinball_game_fsm_if #(
  parameter int SCORE_W = 8,
  parameter int LEVEL_W = 4,
  parameter int LIFE_W  = 4
);

  logic               startOfFrame;
  logic               keyStart;
  logic               keyPause;
  logic               collisionSmileyBorderBottom;
  logic               collisionSmileyObstacle;
  logic               collisionSmileyObstacleGood;
  logic               collisionSmileyObstacleBad;

  logic               pause;
  logic               reset_level;
  logic [SCORE_W-1:0] score;
  logic [LEVEL_W-1:0] level;
  logic [LIFE_W-1:0]  life;
  logic               game_over;
  logic               game_won;
  logic [2:0]         state_code;

  modport master (
    output startOfFrame, keyStart, keyPause,
    output collisionSmileyBorderBottom, collisionSmileyObstacle,
    output collisionSmileyObstacleGood, collisionSmileyObstacleBad,
    input  pause, reset_level, score, level, life,
    input  game_over, game_won, state_code
  );

  modport slave (
    input  startOfFrame, keyStart, keyPause,
    input  collisionSmileyBorderBottom, collisionSmileyObstacle,
    input  collisionSmileyObstacleGood, collisionSmileyObstacleBad,
    output pause, reset_level, score, level, life,
    output game_over, game_won, state_code
  );

endinterface

// File: rtl/pinball_game_fsm_frame_timer.sv
// Loadable down-counter that steps once per frame tick and rests at zero.
// Clear beats load, and load beats a tick arriving in the same cycle.
module frame_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         tick_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         clear_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/pinball_game_fsm.sv
// Game-flow controller: serve/play/pause, lost-ball and level-up delays,
// score/level/life bookkeeping and the terminal game-over and win states.
module pinball_game_fsm
  import defines::*;
#(
  parameter int SCORE_W        = 8,
  parameter int LEVEL_W        = 4,
  parameter int LIFE_W         = 4,
  parameter int LIFE_INIT      = DEF_LIFE_INIT,
  parameter int LIFE_MAX       = DEF_LIFE_MAX,
  parameter int SCORE_TARGET   = DEF_SCORE_TARGET,
  parameter int LEVEL_MAX      = DEF_LEVEL_MAX,
  parameter int GOOD_POINTS    = 1,
  parameter int BAD_POINTS     = 1,
  parameter int DELAY_FRAMES   = DEF_DELAY_FRAMES,
  parameter int HOLDOFF_FRAMES = DEF_HOLDOFF_FRAMES
) (
  input  logic              clk,
  input  logic              resetN,
  pinball_game_fsm_if.slave bus
);

  localparam int DLY_W = timer_width(DELAY_FRAMES);
  localparam int HLD_W = timer_width(HOLDOFF_FRAMES);

  if (SCORE_TARGET >= (1 << SCORE_W)) begin : g_target_check
    $error("SCORE_TARGET does not fit in SCORE_W bits");
  end

  game_state_t        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LIFE_W-1:0]  life_q, life_d;
  logic               key_start_q, key_pause_q;

  logic               start_edge, pause_edge;
  logic               hit_good, hit_bad;
  logic               delay_load, delay_done;
  logic               hold_load, hold_clear, hold_done;

  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_add, score_sub;
  logic [LEVEL_W-1:0] level_inc;
  logic [LIFE_W-1:0]  life_inc, life_dec;

  assign start_edge = bus.keyStart & ~key_start_q;
  assign pause_edge = bus.keyPause & ~key_pause_q;

  // Good takes precedence when a collision reports both qualities.
  assign hit_good = bus.collisionSmileyObstacle & hold_done & bus.collisionSmileyObstacleGood;
  assign hit_bad  = bus.collisionSmileyObstacle & hold_done & ~bus.collisionSmileyObstacleGood
                  & bus.collisionSmileyObstacleBad;

  // Saturating arithmetic so no counter ever wraps.
  assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(GOOD_POINTS);
  assign score_add = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  assign score_sub = (score_q >= SCORE_W'(BAD_POINTS)) ? (score_q - SCORE_W'(BAD_POINTS)) : '0;
  assign level_inc = (level_q == {LEVEL_W{1'b1}}) ? level_q : (level_q + 1'b1);
  assign life_dec  = (life_q == '0) ? life_q : (life_q - 1'b1);
  assign life_inc  = ((life_q >= LIFE_W'(LIFE_MAX)) || (life_q == {LIFE_W{1'b1}}))
                   ? life_q : (life_q + 1'b1);

  frame_timer #(.W(DLY_W)) u_delay_timer (
    .clk        (clk),
    .resetN     (resetN),
    .tick_i     (bus.startOfFrame),
    .load_i     (delay_load),
    .load_val_i (DLY_W'(DELAY_FRAMES)),
    .clear_i    (1'b0),
    .done_o     (delay_done)
  );

  frame_timer #(.W(HLD_W)) u_holdoff_timer (
    .clk        (clk),
    .resetN     (resetN),
    .tick_i     (bus.startOfFrame),
    .load_i     (hold_load),
    .load_val_i (HLD_W'(HOLDOFF_FRAMES)),
    .clear_i    (hold_clear),
    .done_o     (hold_done)
  );

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    level_d    = level_q;
    life_d     = life_q;
    delay_load = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;

    case (state_q)
      SERVE: begin
        score_d = '0;
        if (start_edge) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (bus.collisionSmileyBorderBottom) begin
          life_d = life_dec;
          if (life_dec == '0) begin
            state_d = OVER;
          end else begin
            state_d    = LOST;
            delay_load = 1'b1;
          end
        end else if (pause_edge) begin
          state_d = PAUSED;
        end else if (hit_good) begin
          hold_load = 1'b1;
          score_d   = score_add;
          // Level bookkeeping happens on the way into LEVEL_UP.
          if (score_add >= SCORE_W'(SCORE_TARGET)) begin
            state_d    = LEVEL_UP;
            delay_load = 1'b1;
            level_d    = level_inc;
            life_d     = life_inc;
          end
        end else if (hit_bad) begin
          hold_load = 1'b1;
          score_d   = score_sub;
        end
      end

      PAUSED: begin
        if (pause_edge || start_edge) begin
          state_d = PLAY;
        end
      end

      LOST: begin
        if (delay_done) begin
          state_d = SERVE;
        end
      end

      LEVEL_UP: begin
        if (level_q == LEVEL_W'(LEVEL_MAX)) begin
          state_d = WIN;
        end else if (delay_done) begin
          state_d = SERVE;
        end
      end

      OVER, WIN: begin
        if (start_edge) begin
          state_d = SERVE;
          level_d = '0;
          life_d  = LIFE_W'(LIFE_INIT);
        end
      end

      default: begin
        state_d = SERVE;
      end
    endcase

    // Every entry into SERVE starts a fresh ball with no hold-off pending.
    if ((state_d == SERVE) && (state_q != SERVE)) begin
      score_d    = '0;
      hold_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= SERVE;
      score_q     <= '0;
      level_q     <= '0;
      life_q      <= LIFE_W'(LIFE_INIT);
      key_start_q <= 1'b0;
      key_pause_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      level_q     <= level_d;
      life_q      <= life_d;
      key_start_q <= bus.keyStart;
      key_pause_q <= bus.keyPause;
    end
  end

  assign bus.pause       = (state_q != PLAY);
  assign bus.reset_level = (state_q != PLAY) && (state_q != PAUSED);
  assign bus.game_over   = (state_q == OVER);
  assign bus.game_won    = (state_q == WIN);
  assign bus.state_code  = state_q;
  assign bus.score       = score_q;
  assign bus.level       = level_q;
  assign bus.life        = life_q;

endmodule

// File: tb/tb_pinball_game_fsm.sv
// Scoreboard bench for the game-flow controller: each checked cycle pushes its
// expected state/score/level/life before driving, then pops and compares.
module tb_pinball_game_fsm;
  import defines::*;

  localparam int SCORE_W = 8;
  localparam int LEVEL_W = 4;
  localparam int LIFE_W  = 4;

  // Input bundle bits: {sof, keyStart, keyPause, bottom, obstacle, good, bad}
  localparam logic [6:0] I_NONE = 7'h00;
  localparam logic [6:0] I_SOF  = 7'h40;
  localparam logic [6:0] I_KS   = 7'h20;
  localparam logic [6:0] I_KP   = 7'h10;
  localparam logic [6:0] I_BOT  = 7'h08;
  localparam logic [6:0] I_OBS  = 7'h04;
  localparam logic [6:0] I_GOOD = 7'h02;
  localparam logic [6:0] I_BAD  = 7'h01;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  pinball_game_fsm_if #(.SCORE_W(SCORE_W), .LEVEL_W(LEVEL_W), .LIFE_W(LIFE_W)) bus ();

  pinball_game_fsm #(
    .SCORE_W(SCORE_W), .LEVEL_W(LEVEL_W), .LIFE_W(LIFE_W),
    .LIFE_INIT(3), .LIFE_MAX(9), .SCORE_TARGET(10), .LEVEL_MAX(2),
    .GOOD_POINTS(1), .BAD_POINTS(1), .DELAY_FRAMES(4), .HOLDOFF_FRAMES(8)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    game_state_t st;
    int          score;
    int          level;
    int          life;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input game_state_t st, input int sc, input int lv,
                         input int lf);
    exp_t e;
    e.tag   = tag;
    e.st    = st;
    e.score = sc;
    e.level = lv;
    e.life  = lf;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    $display("%-16s state=%0d score=%0d level=%0d life=%0d pause=%0d rl=%0d over=%0d won=%0d",
             e.tag, bus.state_code, bus.score, bus.level, bus.life, bus.pause,
             bus.reset_level, bus.game_over, bus.game_won);
    check_eq({e.tag, ".state"}, int'(bus.state_code), int'(e.st));
    check_eq({e.tag, ".score"}, int'(bus.score), e.score);
    check_eq({e.tag, ".level"}, int'(bus.level), e.level);
    check_eq({e.tag, ".life"}, int'(bus.life), e.life);
    check_eq({e.tag, ".pause"}, int'(bus.pause), int'(e.st != PLAY));
    check_eq({e.tag, ".reset_level"}, int'(bus.reset_level),
             int'((e.st != PLAY) && (e.st != PAUSED)));
    check_eq({e.tag, ".game_over"}, int'(bus.game_over), int'(e.st == OVER));
    check_eq({e.tag, ".game_won"}, int'(bus.game_won), int'(e.st == WIN));
  endtask

  task automatic drive(input logic [6:0] in);
    bus.startOfFrame                = in[6];
    bus.keyStart                    = in[5];
    bus.keyPause                    = in[4];
    bus.collisionSmileyBorderBottom = in[3];
    bus.collisionSmileyObstacle     = in[2];
    bus.collisionSmileyObstacleGood = in[1];
    bus.collisionSmileyObstacleBad  = in[0];
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [6:0] in, input int n);
    repeat (n) drive(in);
  endtask

  task automatic go(input string tag, input logic [6:0] in, input game_state_t st,
                    input int sc, input int lv, input int lf);
    sb_push(tag, st, sc, lv, lf);
    drive(in);
    sb_pop();
  endtask

  // Serve, then lose a ball and sit out the full delay back to SERVE.
  task automatic lose_ball(input int lv, input int life_before);
    go("serve_start", I_KS, PLAY, 0, lv, life_before);
    go("serve_rel", I_NONE, PLAY, 0, lv, life_before);
    go("ball_lost", I_BOT, LOST, 0, lv, life_before - 1);
    run(I_SOF, 4);
    go("back_to_serve", I_NONE, SERVE, 0, lv, life_before - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(I_NONE);
    go("reset", I_NONE, SERVE, 0, 0, 3);
    resetN = 1'b1;
    go("idle_serve", I_NONE, SERVE, 0, 0, 3);

    // Level 0: ten good hits spaced past the hold-off.
    go("start", I_KS, PLAY, 0, 0, 3);
    go("start_rel", I_NONE, PLAY, 0, 0, 3);
    go("hit1", I_OBS | I_GOOD, PLAY, 1, 0, 3);
    run(I_SOF, 7);
    go("holdoff_block", I_OBS | I_GOOD, PLAY, 1, 0, 3);
    run(I_SOF, 1);
    for (int i = 2; i <= 9; i++) begin
      go("good_hit", I_OBS | I_GOOD, PLAY, i, 0, 3);
      run(I_SOF, 8);
    end
    go("hit10_lvlup", I_OBS | I_GOOD, LEVEL_UP, 10, 1, 4);
    run(I_SOF, 3);
    go("lvlup_wait", I_NONE, LEVEL_UP, 10, 1, 4);
    go("lvlup_tick4", I_SOF, LEVEL_UP, 10, 1, 4);
    go("lvlup_serve", I_NONE, SERVE, 0, 1, 4);

    // Level 1: bad hits, held collision, hit qualifiers.
    go("start_l1", I_KS, PLAY, 0, 1, 4);
    go("start_l1_rel", I_NONE, PLAY, 0, 1, 4);
    go("bad_at_zero", I_OBS | I_BAD, PLAY, 0, 1, 4);
    run(I_SOF, 8);
    for (int f = 0; f < 5; f++) begin
      drive(I_SOF | I_OBS | I_GOOD);
      drive(I_OBS | I_GOOD);
      drive(I_OBS | I_GOOD);
    end
    go("held_once", I_OBS | I_GOOD, PLAY, 1, 1, 4);
    run(I_SOF, 4);
    go("good2", I_OBS | I_GOOD, PLAY, 2, 1, 4);
    run(I_SOF, 8);
    go("good3", I_OBS | I_GOOD, PLAY, 3, 1, 4);
    run(I_SOF, 8);
    go("bad_3to2", I_OBS | I_BAD, PLAY, 2, 1, 4);
    run(I_SOF, 8);
    go("neither", I_OBS, PLAY, 2, 1, 4);
    go("after_neither", I_OBS | I_GOOD, PLAY, 3, 1, 4);
    run(I_SOF, 8);
    go("good_and_bad", I_OBS | I_GOOD | I_BAD, PLAY, 4, 1, 4);
    run(I_SOF, 8);

    // Pause and resume.
    go("pause_on", I_KP, PAUSED, 4, 1, 4);
    go("paused_coll", I_KP | I_OBS | I_GOOD | I_BOT, PAUSED, 4, 1, 4);
    go("kp_rel", I_NONE, PAUSED, 4, 1, 4);
    go("pause_off", I_KP, PLAY, 4, 1, 4);
    go("kp_rel2", I_NONE, PLAY, 4, 1, 4);
    run(I_KP, 19);
    go("kp_held20", I_KP, PAUSED, 4, 1, 4);
    go("kp_rel3", I_NONE, PAUSED, 4, 1, 4);
    go("ks_resume", I_KS, PLAY, 4, 1, 4);
    go("ks_rel", I_NONE, PLAY, 4, 1, 4);
    go("pause_vs_hit", I_KP | I_OBS | I_GOOD, PAUSED, 4, 1, 4);
    go("kp_rel4", I_NONE, PAUSED, 4, 1, 4);
    go("resume2", I_KP, PLAY, 4, 1, 4);
    go("kp_rel5", I_NONE, PLAY, 4, 1, 4);

    // Lost ball with a simultaneous hit, then the exact delay.
    go("bot_lost", I_BOT | I_OBS | I_GOOD, LOST, 4, 1, 3);
    run(I_SOF, 3);
    go("lost_wait", I_NONE, LOST, 4, 1, 3);
    go("lost_tick4", I_SOF, LOST, 4, 1, 3);
    go("lost_serve", I_NONE, SERVE, 0, 1, 3);

    // Clear the last level to win.
    go("start_l1b", I_KS, PLAY, 0, 1, 3);
    go("start_l1b_rel", I_NONE, PLAY, 0, 1, 3);
    for (int i = 1; i <= 9; i++) begin
      go("good_hit_l1", I_OBS | I_GOOD, PLAY, i, 1, 3);
      run(I_SOF, 8);
    end
    go("hit10_last", I_OBS | I_GOOD, LEVEL_UP, 10, 2, 4);
    go("win", I_NONE, WIN, 10, 2, 4);
    go("win_hold", I_SOF, WIN, 10, 2, 4);
    go("win_restart", I_KS, SERVE, 0, 0, 3);
    go("win_rel", I_NONE, SERVE, 0, 0, 3);

    // Run out of lives.
    lose_ball(0, 3);
    lose_ball(0, 2);
    go("start_last", I_KS, PLAY, 0, 0, 1);
    go("start_last_rel", I_NONE, PLAY, 0, 0, 1);
    go("last_good", I_OBS | I_GOOD, PLAY, 1, 0, 1);
    run(I_SOF, 8);
    go("bot_over", I_BOT | I_OBS | I_GOOD, OVER, 1, 0, 0);
    go("over_hold", I_SOF, OVER, 1, 0, 0);
    go("over_restart", I_KS, SERVE, 0, 0, 3);
    go("over_rel", I_NONE, SERVE, 0, 0, 3);

    // Asynchronous reset in the middle of the lost-ball delay.
    go("start_rst", I_KS, PLAY, 0, 0, 3);
    go("start_rst_rel", I_NONE, PLAY, 0, 0, 3);
    go("lost_rst", I_BOT, LOST, 0, 0, 2);
    run(I_SOF, 2);
    resetN = 1'b0;
    sb_push("async_reset", SERVE, 0, 0, 3);
    #2;
    sb_pop();
    go("reset_held", I_SOF, SERVE, 0, 0, 3);
    resetN = 1'b1;
    go("after_reset", I_NONE, SERVE, 0, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
